// File: rtl/montgomery_ctrl.sv
// Bit-serial Montgomery product sequencer (R = A*B*2^-NBITS mod M) driving one external registered adder.
// Define MONT_SKIP_ZERO_EN to skip the C+0 adder operation for zero multiplier bits (variable latency).
module montgomery_ctrl #(
   parameter int unsigned NBITS = 512,
   parameter int unsigned CNT_W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [513:0] in_a,
   input  logic [513:0] in_b,
   input  logic [513:0] in_m,
   output logic [513:0] result,
   output logic         done,
   output logic         busy,
   output logic         add_start,
   output logic         add_subtract,
   output logic         add_shift,
   output logic [513:0] add_in_a,
   output logic [513:0] add_in_b,
   input  logic [514:0] add_result,
   input  logic         add_done
);

   localparam int unsigned W = 514;

   typedef enum logic [2:0] {
      S_IDLE, S_ADD_B, S_WAIT_B, S_ADD_M, S_WAIT_M, S_SUB, S_WAIT_S, S_DONE
   } state_t;

   state_t           state, state_d;
   state_t           first_op, next_op;
   logic [W-1:0]     a_q, b_q, m_q, c_q;
   logic [W-1:0]     a_d, b_d, m_d, c_d;
   logic [CNT_W-1:0] i_q, i_d;
   logic [W-1:0]     result_d, add_in_b_d;
   logic             done_d, busy_d, add_start_d, add_subtract_d, add_shift_d;
   logic             last_iter;

   assign last_iter = (i_q == CNT_W'(NBITS - 1));
   assign add_in_a  = c_q;

   // a_q is shifted right per iteration, so bit 1 is the multiplier bit of the next iteration
`ifdef MONT_SKIP_ZERO_EN
   assign first_op = in_a[0] ? S_ADD_B : S_ADD_M;
   assign next_op  = a_q[1]  ? S_ADD_B : S_ADD_M;
`else
   assign first_op = S_ADD_B;
   assign next_op  = S_ADD_B;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:   if (start) state_d = first_op;
         S_ADD_B:  state_d = S_WAIT_B;
         S_WAIT_B: if (add_done) state_d = S_ADD_M;
         S_ADD_M:  state_d = S_WAIT_M;
         S_WAIT_M: if (add_done) state_d = last_iter ? S_SUB : next_op;
         S_SUB:    state_d = S_WAIT_S;
         S_WAIT_S: if (add_done) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath updates and adder command decode; commands follow the next state so they register cleanly
   always_comb begin
      a_d            = a_q;
      b_d            = b_q;
      m_d            = m_q;
      c_d            = c_q;
      i_d            = i_q;
      result_d       = result;
      add_in_b_d     = add_in_b;
      add_subtract_d = add_subtract;
      add_shift_d    = add_shift;
      add_start_d    = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               a_d = in_a;
               b_d = in_b;
               m_d = in_m;
               c_d = '0;
               i_d = '0;
            end
         end
         S_WAIT_B: if (add_done) c_d = add_result[W-1:0];
         S_WAIT_M: begin
            if (add_done) begin
               c_d = add_result[W-1:0];
               a_d = a_q >> 1;
               i_d = i_q + CNT_W'(1);
            end
         end
         S_WAIT_S: if (add_done) result_d = add_result[W] ? c_q : add_result[W-1:0];
         default: ;
      endcase

      case (state_d)
         S_ADD_B: begin
            add_start_d    = 1'b1;
            add_subtract_d = 1'b0;
            add_shift_d    = 1'b0;
            add_in_b_d     = a_d[0] ? b_d : '0;
         end
         S_ADD_M: begin
            add_start_d    = 1'b1;
            add_subtract_d = 1'b0;
            add_shift_d    = 1'b1;
            add_in_b_d     = c_d[0] ? m_d : '0;
         end
         S_SUB: begin
            add_start_d    = 1'b1;
            add_subtract_d = 1'b1;
            add_shift_d    = 1'b0;
            add_in_b_d     = m_d;
         end
         default: ;
      endcase

      done_d = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
   end

   // Registered datapath and outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q          <= '0;
         b_q          <= '0;
         m_q          <= '0;
         c_q          <= '0;
         i_q          <= '0;
         result       <= '0;
         done         <= 1'b0;
         busy         <= 1'b0;
         add_start    <= 1'b0;
         add_subtract <= 1'b0;
         add_shift    <= 1'b0;
         add_in_b     <= '0;
      end else begin
         a_q          <= a_d;
         b_q          <= b_d;
         m_q          <= m_d;
         c_q          <= c_d;
         i_q          <= i_d;
         result       <= result_d;
         done         <= done_d;
         busy         <= busy_d;
         add_start    <= add_start_d;
         add_subtract <= add_subtract_d;
         add_shift    <= add_shift_d;
         add_in_b     <= add_in_b_d;
      end
   end

endmodule

// File: tb/tb_montgomery_ctrl.sv
// Directed bench for montgomery_ctrl: NBITS=4 hand-computed vectors plus a few NBITS=512 vectors.
module tb_montgomery_ctrl;

   localparam int unsigned W = 514;
`ifdef MONT_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // NBITS=4 instance
   logic         start4;
   logic [W-1:0] in_a4, in_b4, in_m4, result4, ain4, bin4;
   logic         done4, busy4, as4, asub4, ash4;
   logic [W:0]   ares4  = '0;
   logic         adone4 = 1'b0;

   montgomery_ctrl #(.NBITS(4), .CNT_W(3)) dut4 (
      .clk(clk), .reset(reset), .start(start4),
      .in_a(in_a4), .in_b(in_b4), .in_m(in_m4),
      .result(result4), .done(done4), .busy(busy4),
      .add_start(as4), .add_subtract(asub4), .add_shift(ash4),
      .add_in_a(ain4), .add_in_b(bin4),
      .add_result(ares4), .add_done(adone4)
   );

   // NBITS=512 instance
   logic         start5;
   logic [W-1:0] in_a5, in_b5, in_m5, result5, ain5, bin5;
   logic         done5, busy5, as5, asub5, ash5;
   logic [W:0]   ares5  = '0;
   logic         adone5 = 1'b0;

   montgomery_ctrl #(.NBITS(512), .CNT_W(10)) dut512 (
      .clk(clk), .reset(reset), .start(start5),
      .in_a(in_a5), .in_b(in_b5), .in_m(in_m5),
      .result(result5), .done(done5), .busy(busy5),
      .add_start(as5), .add_subtract(asub5), .add_shift(ash5),
      .add_in_a(ain5), .add_in_b(bin5),
      .add_result(ares5), .add_done(adone5)
   );

   // Registered adder models (done one cycle after start, not reset)
   always @(posedge clk) begin
      adone4 <= as4;
      if (as4) begin
         if (asub4)     ares4 <= {1'b0, ain4} - {1'b0, bin4};
         else if (ash4) ares4 <= ({1'b0, ain4} + {1'b0, bin4}) >> 1;
         else           ares4 <= {1'b0, ain4} + {1'b0, bin4};
      end
      adone5 <= as5;
      if (as5) begin
         if (asub5)     ares5 <= {1'b0, ain5} - {1'b0, bin5};
         else if (ash5) ares5 <= ({1'b0, ain5} + {1'b0, bin5}) >> 1;
         else           ares5 <= {1'b0, ain5} + {1'b0, bin5};
      end
   end

   // Runs one NBITS=4 operation; start is cycle 0, optional re-pulses at re1/re2
   task automatic run4(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                       input int re1, input int re2,
                       output logic [W-1:0] res, output logic [W-1:0] sub_a, output int dcyc,
                       output int pulses, output int b2b, output int busy_bad);
      int   cyc;
      logic prev;
      res = '0; sub_a = '0; dcyc = -1; pulses = 0; b2b = 0; busy_bad = 0; prev = 1'b0;
      @(posedge clk); #1;
      in_a4 = a; in_b4 = b; in_m4 = m; start4 = 1'b1; cyc = 0;
      while (cyc < 200) begin
         @(negedge clk);
         if (as4) pulses++;
         if (as4 && prev) b2b++;
         prev = as4;
         if (as4 && asub4) sub_a = ain4;
         if (cyc > 0 && !done4 && !busy4) busy_bad++;
         if (done4) begin
            dcyc = cyc;
            res  = result4;
            if (busy4) busy_bad++;
            break;
         end
         @(posedge clk); #1;
         cyc++;
         start4 = (cyc == re1) || (cyc == re2);
         in_a4  = W'(15);
         in_b4  = W'(12);
         in_m4  = W'(11);
      end
   endtask

   task automatic test_init;
      @(negedge clk);
      checks++; if (done4 !== 1'b0) begin failures++; $display("FAIL init_done: got %0d expected 0", done4); end
      checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL init_busy: got %0d expected 0", busy4); end
      checks++; if (as4 !== 1'b0) begin failures++; $display("FAIL init_add_start: got %0d expected 0", as4); end
      checks++; if (result4 !== W'(0)) begin failures++; $display("FAIL init_result: got %0d expected 0", result4); end
   endtask

   task automatic test_basic;
      logic [W-1:0] res, sa;
      int dc, p, bb, bz;
      run4(W'(7), W'(5), W'(13), -1, -1, res, sa, dc, p, bb, bz);
      checks++; if (res !== W'(3)) begin failures++; $display("FAIL basic_result: got %0d expected 3", res); end
      checks++; if (sa !== W'(3)) begin failures++; $display("FAIL basic_presub_c: got %0d expected 3", sa); end
      checks++; if (dc !== (SKIP ? 17 : 19)) begin failures++; $display("FAIL basic_done_cycle: got %0d expected %0d", dc, SKIP ? 17 : 19); end
      checks++; if (bb !== 0) begin failures++; $display("FAIL basic_back_to_back: got %0d expected 0", bb); end
      checks++; if (bz !== 0) begin failures++; $display("FAIL basic_busy: got %0d bad cycles expected 0", bz); end
   endtask

   task automatic test_final_subtract;
      logic [W-1:0] res, sa;
      int dc, p, bb, bz;
      run4(W'(15), W'(12), W'(13), -1, -1, res, sa, dc, p, bb, bz);
      checks++; if (sa !== W'(21)) begin failures++; $display("FAIL sub_presub_c: got %0d expected 21", sa); end
      checks++; if (res !== W'(8)) begin failures++; $display("FAIL sub_result: got %0d expected 8", res); end
      checks++; if (dc !== 19) begin failures++; $display("FAIL sub_done_cycle: got %0d expected 19", dc); end
      @(negedge clk);
      checks++; if (done4 !== 1'b0) begin failures++; $display("FAIL sub_done_width: got %0d expected 0", done4); end
      checks++; if (result4 !== W'(8)) begin failures++; $display("FAIL sub_result_hold: got %0d expected 8", result4); end
   endtask

   task automatic test_zero_bits;
      logic [W-1:0] res, sa;
      int dc, p, bb, bz;
      run4(W'(12), W'(12), W'(13), -1, -1, res, sa, dc, p, bb, bz);
      checks++; if (res !== W'(9)) begin failures++; $display("FAIL zero_result: got %0d expected 9", res); end
      checks++; if (p !== (SKIP ? 7 : 9)) begin failures++; $display("FAIL zero_pulses: got %0d expected %0d", p, SKIP ? 7 : 9); end
      checks++; if (dc !== (SKIP ? 15 : 19)) begin failures++; $display("FAIL zero_done_cycle: got %0d expected %0d", dc, SKIP ? 15 : 19); end
   endtask

   task automatic test_restart_ignored;
      logic [W-1:0] res, sa;
      int dc, p, bb, bz;
      run4(W'(7), W'(5), W'(13), 3, 10, res, sa, dc, p, bb, bz);
      checks++; if (res !== W'(3)) begin failures++; $display("FAIL restart_result: got %0d expected 3", res); end
      checks++; if (bz !== 0) begin failures++; $display("FAIL restart_busy: got %0d bad cycles expected 0", bz); end
      checks++; if (dc !== (SKIP ? 17 : 19)) begin failures++; $display("FAIL restart_done_cycle: got %0d expected %0d", dc, SKIP ? 17 : 19); end
   endtask

   task automatic test_reset;
      logic [W-1:0] res, sa;
      int dc, p, bb, bz, quiet_bad;
      @(posedge clk); #1;
      in_a4 = W'(7); in_b4 = W'(5); in_m4 = W'(13); start4 = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         start4 = 1'b0;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0d expected 0", busy4); end
      checks++; if (done4 !== 1'b0) begin failures++; $display("FAIL rst_done: got %0d expected 0", done4); end
      checks++; if (as4 !== 1'b0) begin failures++; $display("FAIL rst_add_start: got %0d expected 0", as4); end
      checks++; if (asub4 !== 1'b0 || ash4 !== 1'b0) begin failures++; $display("FAIL rst_add_mode: got sub=%0d shift=%0d expected 0 0", asub4, ash4); end
      checks++; if (result4 !== W'(0)) begin failures++; $display("FAIL rst_result: got %0d expected 0", result4); end
      checks++; if (ain4 !== W'(0) || bin4 !== W'(0)) begin failures++; $display("FAIL rst_operands: got a=%0d b=%0d expected 0 0", ain4, bin4); end
      quiet_bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (as4 || busy4 || done4) quiet_bad++;
      end
      checks++; if (quiet_bad !== 0) begin failures++; $display("FAIL rst_quiet: got %0d active cycles expected 0", quiet_bad); end
      run4(W'(7), W'(5), W'(13), -1, -1, res, sa, dc, p, bb, bz);
      checks++; if (res !== W'(3)) begin failures++; $display("FAIL rst_rerun_result: got %0d expected 3", res); end
   endtask

   task automatic test_wide;
      logic [W-1:0]  a, b, m, res, t;
      logic [1039:0] lhs, rhs;
      int cyc, dcyc, b2b, exp_cyc;
      logic prev;
      for (int v = 0; v < 3; v++) begin
         m = '0;
         for (int k = 0; k < 16; k++) m[k*32 +: 32] = $urandom;
         m[511] = 1'b1;
         m[0]   = 1'b1;
         if (v == 2) begin
            a = m - W'(1);
            b = m - W'(1);
         end else begin
            t = '0;
            for (int k = 0; k < 16; k++) t[k*32 +: 32] = $urandom;
            a = t % m;
            for (int k = 0; k < 16; k++) t[k*32 +: 32] = $urandom;
            b = t % m;
         end
         exp_cyc = SKIP ? 2051 - 2 * (512 - $countones(a[511:0])) : 2051;
         @(posedge clk); #1;
         in_a5 = a; in_b5 = b; in_m5 = m; start5 = 1'b1;
         cyc = 0; dcyc = -1; b2b = 0; prev = 1'b0; res = '0;
         while (cyc < 2300) begin
            @(negedge clk);
            if (as5 && prev) b2b++;
            prev = as5;
            if (done5) begin
               dcyc = cyc;
               res  = result5;
               break;
            end
            @(posedge clk); #1;
            start5 = 1'b0;
            cyc++;
         end
         lhs = ({526'b0, res} << 512) % {526'b0, m};
         rhs = ({526'b0, a} * {526'b0, b}) % {526'b0, m};
         checks++; if (lhs !== rhs) begin failures++; $display("FAIL wide_product_%0d: got %0h expected congruent to %0h", v, lhs, rhs); end
         checks++; if (!(res < m)) begin failures++; $display("FAIL wide_range_%0d: got %0h expected below %0h", v, res, m); end
         checks++; if (dcyc !== exp_cyc) begin failures++; $display("FAIL wide_done_cycle_%0d: got %0d expected %0d", v, dcyc, exp_cyc); end
         checks++; if (b2b !== 0) begin failures++; $display("FAIL wide_back_to_back_%0d: got %0d expected 0", v, b2b); end
      end
   endtask

   initial begin
      reset  = 1'b1;
      start4 = 1'b0; in_a4 = '0; in_b4 = '0; in_m4 = '0;
      start5 = 1'b0; in_a5 = '0; in_b5 = '0; in_m5 = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      test_init;
      test_basic;
      test_final_subtract;
      test_zero_bits;
      test_restart_ignored;
      test_reset;
      test_wide;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
